// File: rtl/uart_link_partner.sv
// Far-end 8N1 UART endpoint: drives the MCU rx line and receives the MCU tx line,
// with a byte FIFO per direction, MCU flow control and sticky error flags.
module uart_link_partner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module uart_link_partner #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_LEVEL = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] baud_counter,
    output logic        tx_line,
    input  logic        rx_line,
    input  logic        mcu_rts,
    output logic        hold_mcu,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        overrun,
    output logic        framing_error,
    input  logic        clear_errors
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    tx_state_t       tx_state, tx_next;
    logic [12:0]     tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_sh;
    logic [11:0]     tx_n;
    logic            tx_pop;
    logic            tx_bit_end;
    logic [7:0]      tx_head;
    logic [CW-1:0]   tx_count;
    logic            tx_full;

    rx_state_t       rx_state, rx_next;
    logic [12:0]     rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_sh;
    logic [11:0]     rx_n;
    logic            rx_meta, rx_s, rx_prev;
    logic            rx_half, rx_bit_end;
    logic            rx_push, rx_pop, fe_set, ovr_set;
    logic [7:0]      rx_head;
    logic [CW-1:0]   rx_count;
    logic            rx_full;

    uart_link_partner_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_valid), .wdata(wr_data), .pop(tx_pop),
        .head(tx_head), .count(tx_count), .full(tx_full)
    );

    uart_link_partner_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
        .head(rx_head), .count(rx_count), .full(rx_full)
    );

    assign wr_ready = !tx_full;
    assign rd_valid = (rx_count != '0);
    assign rd_data  = rd_valid ? rx_head : 8'h00;
    assign rx_pop   = rd_valid && rd_ready;

    // TX: bit period is 2*(N+1) clocks, N latched while idle
    assign tx_bit_end = (tx_cnt == {tx_n, 1'b1});

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE:  if (tx_count != '0 && !mcu_rts) begin
                          tx_pop  = 1'b1;
                          tx_next = TX_START;
                      end
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_sh[0];
            default:  tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_n   <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_n   <= baud_counter;
            tx_cnt <= '0;
            tx_bit <= '0;
        end else if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
        end else begin
            tx_cnt <= tx_cnt + 13'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop)
            tx_sh <= tx_head;
        else if (tx_state == TX_DATA && tx_bit_end)
            tx_sh <= {1'b0, tx_sh[7:1]};
    end

    // RX: rx_prev starts low, so a start edge needs rx_s to have been high once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx_line;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign rx_half    = (rx_cnt == {1'b0, rx_n});
    assign rx_bit_end = (rx_cnt == {rx_n, 1'b1});

    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        fe_set  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) begin
                          if (rx_s) begin
                              rx_push = 1'b1;
                              rx_next = RX_IDLE;
                          end else begin
                              fe_set  = 1'b1;
                              rx_next = RX_WAIT;
                          end
                      end
            RX_WAIT:  if (rx_s) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    assign ovr_set = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_n   <= '0;
        end else if (rx_state == RX_IDLE || rx_state == RX_WAIT) begin
            rx_n   <= baud_counter;
            rx_cnt <= '0;
            rx_bit <= '0;
        end else if ((rx_state == RX_START && rx_half) || rx_bit_end) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) rx_bit <= rx_bit + 3'd1;
        end else begin
            rx_cnt <= rx_cnt + 13'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_bit_end)
            rx_sh <= {rx_s, rx_sh[7:1]};
    end

    // the in-flight byte counts toward the threshold once its data phase starts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_mcu      <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            hold_mcu <= (rx_count >= CW'(HOLD_LEVEL)) ||
                        ((rx_count == CW'(HOLD_LEVEL - 1)) &&
                         (rx_state == RX_DATA || rx_state == RX_STOP));
            if (ovr_set)           overrun <= 1'b1;
            else if (clear_errors) overrun <= 1'b0;
            if (fe_set)            framing_error <= 1'b1;
            else if (clear_errors) framing_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_link_partner.sv
// Bench for uart_link_partner: TX frames decoded by a line monitor against a byte
// queue, RX frames driven serially with received bytes checked against a queue.
module tb_uart_link_partner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] baud_counter;
    logic        tx_line;
    logic        rx_line;
    logic        mcu_rts;
    logic        hold_mcu;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready;
    logic        overrun;
    logic        framing_error;
    logic        clear_errors;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int tcur  = 8;
    bit mon_abort = 1'b0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         starts[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_fe;
    } rx_vec_t;

    rx_vec_t    rx_tab[5];
    logic [7:0] tx_tab[4];

    uart_link_partner #(.FIFO_DEPTH(4), .HOLD_LEVEL(3)) dut (
        .clk(clk), .rst_n(rst_n), .baud_counter(baud_counter), .tx_line(tx_line),
        .rx_line(rx_line), .mcu_rts(mcu_rts), .hold_mcu(hold_mcu), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ready(rd_ready), .overrun(overrun), .framing_error(framing_error),
        .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decodes every frame seen on tx_line at mid-bit and compares with the queue
    initial begin
        logic [7:0] got;
        logic       start_ok, stop_ok, abort;
        int         half, last;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            if (!mon_abort && tx_line === 1'b0) begin
                starts.push_back(cyc);
                half = tcur / 2;
                last = half + 9 * tcur;
                abort = 1'b0; got = '0; start_ok = 1'b0; stop_ok = 1'b0;
                for (int k = 1; k <= last; k++) begin
                    @(negedge clk);
                    if (mon_abort) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k == half) start_ok = (tx_line === 1'b0);
                    for (int j = 0; j < 8; j++)
                        if (k == half + tcur * (j + 1)) got[j] = tx_line;
                    if (k == last) stop_ok = (tx_line === 1'b1);
                end
                if (!abort) begin
                    if (tx_exp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL tx_unexpected_frame: got byte %0h with none queued", got);
                    end else begin
                        check("tx_frame_byte", {start_ok, stop_ok, got}, {2'b11, tx_exp.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        check("wr_ready_before_write", wr_ready, 1'b1);
        wr_valid = 1'b1;
        wr_data  = d;
        tx_exp.push_back(d);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input int budget);
        for (int i = 0; i < budget && tx_exp.size() != 0; i++) @(negedge clk);
        check("tx_queue_drained", tx_exp.size(), 0);
    endtask

    task automatic wait_tx_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic exp_push);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        if (exp_push) rx_exp.push_back(d);
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            rx_line = fr[b];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_rx(input string name);
        logic [7:0] exp;
        @(negedge clk);
        check({name, "_valid"}, rd_valid, 1'b1);
        exp = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
        check({name, "_data"}, rd_data, exp);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
    endtask

    initial begin
        bit         ok;
        int         err, rdy_low, low_cnt;
        logic [9:0] fr;

        rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 1'b0};
        rx_tab[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        rx_tab[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        rx_tab[3] = '{8'h81, 1'b0, 1'b0, 1'b1};
        rx_tab[4] = '{8'h55, 1'b1, 1'b1, 1'b0};
        tx_tab    = '{8'h00, 8'hFF, 8'h3C, 8'h81};

        rst_n = 1'b0; baud_counter = 12'd3; rx_line = 1'b1; mcu_rts = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; clear_errors = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_line", tx_line, 1'b1);
        check("reset_hold", hold_mcu, 1'b0);
        check("reset_wr_ready", wr_ready, 1'b1);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_flags", {overrun, framing_error}, 2'b00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // exact A5 waveform, 8 clocks per bit
        wr(8'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        wait_tx_low(ok);
        check("a5_start_seen", ok, 1'b1);
        err = 0; rdy_low = 0;
        for (int i = 0; i < 80; i++) begin
            if (tx_line !== fr[i / 8]) err++;
            if (wr_ready !== 1'b1) rdy_low++;
            @(negedge clk);
        end
        check("a5_wave_errors", err, 0);
        check("a5_wr_ready_low", rdy_low, 0);
        check("a5_idle_after_stop", tx_line, 1'b1);
        wait_tx_done(200);

        foreach (tx_tab[i]) wr(tx_tab[i]);
        wait_tx_done(600);

        // fastest rate: N=0, T=2
        repeat (5) @(negedge clk);
        baud_counter = 12'd0; tcur = 2;
        wr(8'h96);
        wait_tx_done(100);
        repeat (5) @(negedge clk);
        baud_counter = 12'd3; tcur = 8;

        // flow control: nothing leaves while mcu_rts is high
        mcu_rts = 1'b1;
        wr(8'h11);
        wr(8'h22);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_line !== 1'b1) low_cnt++;
        end
        check("rts_line_held", low_cnt, 0);
        starts.delete();
        mcu_rts = 1'b0;
        wait_tx_done(400);
        check("rts_start_count", starts.size(), 2);
        if (starts.size() >= 2) check("rts_start_gap", starts[1] - starts[0], 81);

        foreach (rx_tab[i]) begin
            send_frame(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].exp_valid);
            check("rx_vec_valid", rd_valid, rx_tab[i].exp_valid);
            if (rd_valid) pop_rx("rx_vec");
            check("rx_vec_fe", framing_error, rx_tab[i].exp_fe);
            check("rx_vec_ovr", overrun, 1'b0);
            pulse_clear();
            check("rx_vec_fe_cleared", framing_error, 1'b0);
        end

        // short low glitch must be rejected
        @(negedge clk);
        rx_line = 1'b0;
        repeat (2) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_push", rd_valid, 1'b0);
        check("glitch_no_fe", framing_error, 1'b0);

        // fill past depth without popping
        send_frame(8'hD1, 1'b1, 1'b1);
        fork
            send_frame(8'hD2, 1'b1, 1'b1);
            begin repeat (40) @(negedge clk); check("hold_low_frame2", hold_mcu, 1'b0); end
        join
        fork
            send_frame(8'hD3, 1'b1, 1'b1);
            begin repeat (40) @(negedge clk); check("hold_high_frame3", hold_mcu, 1'b1); end
        join
        send_frame(8'hD4, 1'b1, 1'b1);
        check("hold_full", hold_mcu, 1'b1);
        check("no_overrun_yet", overrun, 1'b0);
        send_frame(8'hD5, 1'b1, 1'b0);
        check("overrun_set", overrun, 1'b1);
        for (int i = 0; i < 4; i++) pop_rx("fill_pop");
        check("fill_drained", rd_valid, 1'b0);
        repeat (2) @(negedge clk);
        check("hold_released", hold_mcu, 1'b0);
        pulse_clear();
        check("overrun_cleared", overrun, 1'b0);

        // reset in the middle of a TX frame
        send_frame(8'h44, 1'b1, 1'b1);
        send_frame(8'h66, 1'b0, 1'b0);
        check("pre_reset_fe", framing_error, 1'b1);
        wr(8'h5A);
        wr(8'h6B);
        wait_tx_low(ok);
        check("rst_frame_started", ok, 1'b1);
        repeat (20) @(negedge clk);
        mon_abort = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_tx_line", tx_line, 1'b1);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_flags", {hold_mcu, overrun, framing_error}, 3'b000);
        repeat (5) @(negedge clk);
        tx_exp.delete();
        rx_exp.delete();
        mon_abort = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_tx_stays_idle", tx_line, 1'b1);

        wr(8'hC3);
        wait_tx_done(200);
        send_frame(8'h3C, 1'b1, 1'b1);
        pop_rx("post_rst_rx");
        check("post_rst_fe", framing_error, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
